// File: rtl/transmissor_medida_pkg.sv
// Shared definitions for the measurement transmitter: state codes, ASCII
// constants, frame geometry and the BCD-to-ASCII helper.
package transmissor_medida_pkg;

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    FIM      = 4'd5
  } estado_t;

  localparam logic [6:0] ASC_ZERO     = 7'h30;
  localparam logic [6:0] ASC_INTERROG = 7'h3F;
  localparam logic [6:0] ASC_DENTRO   = 7'h44;
  localparam logic [6:0] ASC_FORA     = 7'h46;
  localparam logic [6:0] ASC_FIM      = 7'h23;

  localparam int N_CHARS      = 5;
  localparam int N_BITS_DADOS = 7;

  // Non-decimal nibbles are shown as '?' so a corrupted measurement is visible on the line.
  function automatic logic [6:0] bcd_para_ascii(input logic [3:0] d);
    if (d > 4'd9) return ASC_INTERROG;
    return ASC_ZERO | {3'b000, d};
  endfunction

endpackage

// File: rtl/transmissor_medida_contador_m.sv
// Bit-period timer: counts 0..M-1 and flags the last cycle of each bit.
module contador_m #(
  parameter int M = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  output logic tick
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] conta;

  assign tick = (conta == W'(M - 1));

  // Free-running modulo-M counter, restarted by reset or by an explicit clear.
  always_ff @(posedge clock) begin
    if (!reset || limpa) conta <= '0;
    else if (tick)       conta <= '0;
    else                 conta <= conta + 1'b1;
  end

endmodule

// File: rtl/transmissor_medida.sv
// Sends one latched measurement as a 5-character 7O1 UART frame:
// hundreds, tens, units, status ('D'/'F') and '#'.
//
// state    | meaning
// OCIOSO   | idle, line high, waiting for partida
// INICIO   | start bit (low)
// DADOS    | 7 data bits, LSB first
// PARIDADE | odd parity bit
// PARADA   | stop bit (high); next char or FIM
// FIM      | frame done, pronto for one cycle
module transmissor_medida
  import transmissor_medida_pkg::*;
#(
  parameter int CICLOS_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] medida,
  input  logic        dentro,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  estado_t     estado, estado_n;
  logic [2:0]  bit_idx, bit_n;
  logic [2:0]  char_idx, char_n;
  logic [11:0] medida_q;
  logic        dentro_q;
  logic        aceita, limpa, tick;
  logic [6:0]  dado;
  logic        saida_n, ocupado_n, pronto_n;

  assign aceita    = (estado == OCIOSO) && partida;
  assign limpa     = aceita || (estado_n != estado);
  assign db_estado = estado;

  contador_m #(.M(CICLOS_BIT)) u_contador (
    .clock (clock),
    .reset (reset),
    .limpa (limpa),
    .tick  (tick)
  );

  // State and index registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      bit_idx  <= '0;
      char_idx <= '0;
    end else begin
      estado   <= estado_n;
      bit_idx  <= bit_n;
      char_idx <= char_n;
    end
  end

  // Capture the measurement at acceptance so later input changes cannot corrupt the frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      medida_q <= '0;
      dentro_q <= 1'b0;
    end else if (aceita) begin
      medida_q <= medida;
      dentro_q <= dentro;
    end
  end

  // Next state and next bit/char indices.
  always_comb begin
    estado_n = estado;
    bit_n    = bit_idx;
    char_n   = char_idx;
    case (estado)
      OCIOSO: if (partida) begin
        estado_n = INICIO;
        bit_n    = '0;
        char_n   = '0;
      end
      INICIO: if (tick) begin
        estado_n = DADOS;
        bit_n    = '0;
      end
      DADOS: if (tick) begin
        if (bit_idx == 3'(N_BITS_DADOS - 1)) estado_n = PARIDADE;
        else                                 bit_n    = bit_idx + 1'b1;
      end
      PARIDADE: if (tick) estado_n = PARADA;
      PARADA: if (tick) begin
        if (char_idx == 3'(N_CHARS - 1)) begin
          estado_n = FIM;
        end else begin
          estado_n = INICIO;
          char_n   = char_idx + 1'b1;
        end
      end
      FIM:     estado_n = OCIOSO;
      default: estado_n = OCIOSO;
    endcase
  end

  // Character selected by the upcoming char index.
  always_comb begin
    dado = ASC_FIM;
    case (char_n)
      3'd0:    dado = bcd_para_ascii(medida_q[11:8]);
      3'd1:    dado = bcd_para_ascii(medida_q[7:4]);
      3'd2:    dado = bcd_para_ascii(medida_q[3:0]);
      3'd3:    dado = dentro_q ? ASC_DENTRO : ASC_FORA;
      default: dado = ASC_FIM;
    endcase
  end

  // Output values for the upcoming state; registered below so the line changes with the state.
  always_comb begin
    saida_n   = 1'b1;
    ocupado_n = (estado_n != OCIOSO);
    pronto_n  = (estado_n == FIM);
    case (estado_n)
      INICIO:   saida_n = 1'b0;
      DADOS:    saida_n = dado[bit_n];
      PARIDADE: saida_n = ~^dado;
      default:  saida_n = 1'b1;
    endcase
  end

  // Registered outputs keep the UART line and status flags glitch-free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      saida_serial <= saida_n;
      ocupado      <= ocupado_n;
      pronto       <= pronto_n;
    end
  end

endmodule

// File: tb/tb_transmissor_medida.sv
// Directed bench for transmissor_medida. A short bit period keeps the run small;
// all frame timing is expressed in multiples of CB.
module tb_transmissor_medida;

  localparam int CB = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        partida = 1'b0;
  logic [11:0] medida = 12'h000;
  logic        dentro = 1'b0;
  logic        saida_serial, ocupado, pronto;
  logic [3:0]  db_estado;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_pronto = 0;

  transmissor_medida #(.CICLOS_BIT(CB)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .medida       (medida),
    .dentro       (dentro),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (pronto === 1'b1) n_pronto = n_pronto + 1;

  // Requests a frame; returns the cycle number of the acceptance edge.
  task automatic start_frame(input logic [11:0] m, input logic d, input logic hold, output int e);
    @(negedge clock);
    medida  = m;
    dentro  = d;
    partida = 1'b1;
    @(posedge clock);
    #1;
    e = cyc;
    if (!hold) partida = 1'b0;
  endtask

  // Called just after the acceptance edge; samples every bit mid-period and the
  // exact first cycle of each start bit and last cycle of each stop bit.
  // Returns just after edge E+50*CB.
  task automatic capture(output logic [4:0][6:0] ch, output logic [4:0] par, output logic ok);
    ok = 1'b1;
    ch = '0;
    par = '0;
    for (int c = 0; c < 5; c++) begin
      for (int b = 0; b < 10; b++) begin
        if (b == 0 && saida_serial !== 1'b0) ok = 1'b0;
        repeat (CB / 2) @(posedge clock);
        #1;
        if (b == 0 && saida_serial !== 1'b0) ok = 1'b0;
        if (b >= 1 && b <= 7) ch[c][b-1] = saida_serial;
        if (b == 8) par[c] = saida_serial;
        if (b == 9) begin
          if (saida_serial !== 1'b1) ok = 1'b0;
          repeat (CB - CB / 2 - 1) @(posedge clock);
          #1;
          if (saida_serial !== 1'b1) ok = 1'b0;
          @(posedge clock);
          #1;
        end else begin
          repeat (CB - CB / 2) @(posedge clock);
          #1;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (saida_serial !== 1'b1) begin bad++; $display("FAIL reset_line: got %b want 1", saida_serial); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto: got %b want 0", pronto); end
    total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
    reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_frame_100;
    int e;
    logic [4:0][6:0] ch;
    logic [4:0] par;
    logic ok;
    start_frame(12'h100, 1'b0, 1'b0, e);
    total++; if (db_estado !== 4'd1 || ocupado !== 1'b1 || saida_serial !== 1'b0) begin
      bad++; $display("FAIL accept_100: estado=%0d ocupado=%b line=%b want 1 1 0", db_estado, ocupado, saida_serial);
    end
    capture(ch, par, ok);
    total++; if (ch !== {7'h23, 7'h46, 7'h30, 7'h30, 7'h31}) begin
      bad++; $display("FAIL chars_100: got %h want %h", ch, {7'h23, 7'h46, 7'h30, 7'h30, 7'h31});
    end
    total++; if (par !== 5'b00110) begin bad++; $display("FAIL parity_100: got %b want 00110", par); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL framing_100: got %b want 1", ok); end
    total++; if (pronto !== 1'b1 || db_estado !== 4'd5 || cyc - e != 50 * CB) begin
      bad++; $display("FAIL pronto_100: pronto=%b estado=%0d at E+%0d want 1 5 at E+%0d", pronto, db_estado, cyc - e, 50 * CB);
    end
    @(posedge clock);
    #1;
    total++; if (pronto !== 1'b0 || ocupado !== 1'b0 || db_estado !== 4'd0) begin
      bad++; $display("FAIL after_fim_100: pronto=%b ocupado=%b estado=%0d want 0 0 0", pronto, ocupado, db_estado);
    end
  endtask

  task automatic test_frame_075;
    int e;
    logic [4:0][6:0] ch;
    logic [4:0] par;
    logic ok;
    start_frame(12'h075, 1'b1, 1'b0, e);
    capture(ch, par, ok);
    total++; if (ch !== {7'h23, 7'h44, 7'h35, 7'h37, 7'h30}) begin
      bad++; $display("FAIL chars_075: got %h want %h", ch, {7'h23, 7'h44, 7'h35, 7'h37, 7'h30});
    end
    total++; if (par !== 5'b01101) begin bad++; $display("FAIL parity_075: got %b want 01101", par); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL start_spacing_075: got %b want 1", ok); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_frame_0a3;
    int e;
    logic [4:0][6:0] ch;
    logic [4:0] par;
    logic ok;
    start_frame(12'h0A3, 1'b0, 1'b0, e);
    capture(ch, par, ok);
    total++; if (ch !== {7'h23, 7'h46, 7'h33, 7'h3F, 7'h30}) begin
      bad++; $display("FAIL chars_0a3: got %h want %h", ch, {7'h23, 7'h46, 7'h33, 7'h3F, 7'h30});
    end
    total++; if (par !== 5'b00111) begin bad++; $display("FAIL parity_0a3: got %b want 00111", par); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_no_requeue;
    int e;
    int np0;
    logic [4:0][6:0] ch;
    logic [4:0] par;
    logic ok;
    np0 = n_pronto;
    start_frame(12'h042, 1'b1, 1'b0, e);
    fork
      capture(ch, par, ok);
      begin
        repeat (5 * CB) @(posedge clock);
        #1;
        medida  = 12'h999;
        dentro  = 1'b0;
        partida = 1'b1;
        @(posedge clock);
        #1;
        partida = 1'b0;
      end
    join
    total++; if (ch !== {7'h23, 7'h44, 7'h32, 7'h34, 7'h30}) begin
      bad++; $display("FAIL chars_latched: got %h want %h", ch, {7'h23, 7'h44, 7'h32, 7'h34, 7'h30});
    end
    total++; if (par !== 5'b01001) begin bad++; $display("FAIL parity_latched: got %b want 01001", par); end
    repeat (3 * CB) @(posedge clock);
    #1;
    total++; if (n_pronto - np0 != 1 || db_estado !== 4'd0) begin
      bad++; $display("FAIL single_pronto: prontos=%0d estado=%0d want 1 0", n_pronto - np0, db_estado);
    end
  endtask

  task automatic test_reset_mid;
    int e;
    logic [4:0][6:0] ch;
    logic [4:0] par;
    logic ok;
    start_frame(12'h100, 1'b0, 1'b0, e);
    repeat (2 * CB + 2) @(posedge clock);
    #1;
    total++; if (saida_serial !== 1'b0 || db_estado !== 4'd2) begin
      bad++; $display("FAIL pre_reset_line: line=%b estado=%0d want 0 2", saida_serial, db_estado);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    total++; if (saida_serial !== 1'b1 || ocupado !== 1'b0 || db_estado !== 4'd0 || pronto !== 1'b0) begin
      bad++; $display("FAIL mid_reset: line=%b ocupado=%b estado=%0d pronto=%b want 1 0 0 0", saida_serial, ocupado, db_estado, pronto);
    end
    repeat (3) @(posedge clock);
    start_frame(12'h075, 1'b1, 1'b0, e);
    capture(ch, par, ok);
    total++; if (ch !== {7'h23, 7'h44, 7'h35, 7'h37, 7'h30} || par !== 5'b01101 || ok !== 1'b1) begin
      bad++; $display("FAIL frame_after_reset: chars=%h par=%b ok=%b want %h 01101 1", ch, par, ok, {7'h23, 7'h44, 7'h35, 7'h37, 7'h30});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back;
    int e1;
    int e2;
    logic [4:0][6:0] ch;
    logic [4:0] par;
    logic ok;
    start_frame(12'h100, 1'b0, 1'b1, e1);
    capture(ch, par, ok);
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL b2b_pronto1: got %b want 1", pronto); end
    @(posedge clock);
    #1;
    total++; if (ocupado !== 1'b0 || db_estado !== 4'd0 || saida_serial !== 1'b1) begin
      bad++; $display("FAIL b2b_gap: ocupado=%b estado=%0d line=%b want 0 0 1", ocupado, db_estado, saida_serial);
    end
    @(posedge clock);
    #1;
    e2 = cyc;
    partida = 1'b0;
    total++; if (ocupado !== 1'b1 || db_estado !== 4'd1 || e2 - e1 != 50 * CB + 2) begin
      bad++; $display("FAIL b2b_restart: ocupado=%b estado=%0d spacing=%0d want 1 1 %0d", ocupado, db_estado, e2 - e1, 50 * CB + 2);
    end
    capture(ch, par, ok);
    total++; if (ch !== {7'h23, 7'h46, 7'h30, 7'h30, 7'h31} || ok !== 1'b1) begin
      bad++; $display("FAIL b2b_frame2: chars=%h ok=%b want %h 1", ch, ok, {7'h23, 7'h46, 7'h30, 7'h30, 7'h31});
    end
    repeat (4) @(posedge clock);
    #1;
    total++; if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
      bad++; $display("FAIL b2b_stop: estado=%0d ocupado=%b want 0 0", db_estado, ocupado);
    end
  endtask

  initial begin
    test_reset();
    test_frame_100();
    test_frame_075();
    test_frame_0a3();
    test_no_requeue();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
